repetition_code_tx: RTL and testbench

- Serial transmitter for a triple-repetition link. Accepts a parallel word through a val/rdy handshake.
- Shifts the word out MSB-first and drives each data bit on REPS consecutive cycles.
- The far end recovers each bit with a majority vote of the three received copies (pair/triple detection). This block is the sending side that feeds that voter.

---
 rtl/repetition_code_tx.sv | 134 +++++++++++++
 tb/tb_repetition_code_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/repetition_code_tx.sv
// ---------------------------------------------------------------------------
// repetition_code_tx
//   Serial transmitter for a triple-repetition link. A parallel word is taken
//   through a val/rdy handshake, then shifted out MSB-first with every data
//   bit driven on REPS consecutive beats, so a majority voter at the far end
//   can recover each bit even when one copy is corrupted.
//
// Parameters
//   NBITS : payload width in bits (>= 1)
//   REPS  : copies per data bit (odd, >= 3)
//
// Ports
//   clk     : clock, all state updates on posedge
//   rst     : asynchronous reset, active-low
//   in_val  : producer presents a word on in_data
//   in_rdy  : block accepts a word this cycle (independent of in_val)
//   in_data : payload, sampled only on the handshake
//   tx_val  : tx_bit carries a valid beat
//   tx_bit  : current serial beat
//   tx_sof  : first beat of a frame
//   tx_eof  : last beat of a frame
// ---------------------------------------------------------------------------
module repetition_code_tx #(
   parameter int NBITS = 8,
   parameter int REPS  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [NBITS-1:0] in_data,
   output logic             tx_val,
   output logic             tx_bit,
   output logic             tx_sof,
   output logic             tx_eof
);

   localparam int REP_W = (REPS  > 1) ? $clog2(REPS)  : 1;
   localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [NBITS-1:0] sreg_q,  sreg_d;
   logic [REP_W-1:0] rep_q,   rep_d;
   logic [IDX_W-1:0] idx_q,   idx_d;

   logic last_beat;
   logic xfer;

   // State register: reset clears everything so outputs fall to idle values
   // the moment rst goes low, even mid-frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         rep_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         rep_q   <= rep_d;
         idx_q   <= idx_d;
      end
   end

   // Handshake: ready on the final beat as well, so frames can run
   // back-to-back without a bubble. Ready never looks at in_val.
   always_comb begin
      last_beat = (state_q == SEND) && (idx_q == IDX_LAST) && (rep_q == REP_LAST);
      in_rdy    = (state_q == IDLE) || last_beat;
      xfer      = in_val && in_rdy;
   end

   // Output decode
   always_comb begin
      tx_val = 1'b0;
      tx_bit = 1'b0;
      tx_sof = 1'b0;
      tx_eof = 1'b0;
      if (state_q == SEND) begin
         tx_val = 1'b1;
         tx_bit = sreg_q[NBITS-1];
         tx_sof = (idx_q == '0) && (rep_q == '0);
         tx_eof = last_beat;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      rep_d   = rep_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               state_d = SEND;
               sreg_d  = in_data;
               rep_d   = '0;
               idx_d   = '0;
            end
         end
         SEND: begin
            if (last_beat) begin
               // Counters are cleared rather than stepped so neither wraps
               // past its bound; a same-cycle transfer reloads the word.
               rep_d = '0;
               idx_d = '0;
               if (xfer) begin
                  sreg_d = in_data;
               end else begin
                  state_d = IDLE;
                  sreg_d  = '0;
               end
            end else if (rep_q != REP_LAST) begin
               rep_d = rep_q + 1'b1;
            end else begin
               rep_d  = '0;
               idx_d  = idx_q + 1'b1;
               sreg_d = sreg_q << 1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_repetition_code_tx.sv
module tb_repetition_code_tx;

   localparam int NBITS = 8;
   localparam int REPS  = 3;
   localparam int FLEN  = NBITS * REPS;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_val;
   logic             in_rdy;
   logic [NBITS-1:0] in_data;
   logic             tx_val;
   logic             tx_bit;
   logic             tx_sof;
   logic             tx_eof;

   repetition_code_tx #(.NBITS(NBITS), .REPS(REPS)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_val  (in_val),
      .in_rdy  (in_rdy),
      .in_data (in_data),
      .tx_val  (tx_val),
      .tx_bit  (tx_bit),
      .tx_sof  (tx_sof),
      .tx_eof  (tx_eof)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic b;
      logic sof;
      logic eof;
   } beat_t;

   // Reference model: queue of beats still owed on the line.
   beat_t            q[$];
   logic             rx[$];
   logic [NBITS-1:0] sent[$];
   int               checks = 0;
   int               errors = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void push_word(input logic [NBITS-1:0] w);
      beat_t bt;
      for (int i = NBITS - 1; i >= 0; i--) begin
         for (int r = 0; r < REPS; r++) begin
            bt.b   = w[i];
            bt.sof = (i == NBITS - 1) && (r == 0);
            bt.eof = (i == 0) && (r == REPS - 1);
            q.push_back(bt);
         end
      end
   endfunction

   // One clock cycle: drive inputs, check outputs on the falling edge,
   // advance the model on the rising edge.
   task automatic cycle(input logic v, input logic [NBITS-1:0] d, output logic xo);
      beat_t hd;
      logic  ev;
      logic  er;
      logic  xe;
      in_val  = v;
      in_data = d;
      @(negedge clk);
      ev = (q.size() != 0);
      er = (q.size() <= 1);
      if (ev) hd = q[0];
      else    hd = '{b: 1'b0, sof: 1'b0, eof: 1'b0};
      chk1("tx_val", tx_val, ev);
      chk1("tx_bit", tx_bit, hd.b);
      chk1("tx_sof", tx_sof, hd.sof);
      chk1("tx_eof", tx_eof, hd.eof);
      chk1("in_rdy", in_rdy, er);
      xo = v && in_rdy;
      xe = v && er;
      if (tx_val) rx.push_back(tx_bit);
      if (xe) sent.push_back(d);
      @(posedge clk);
      if (ev) void'(q.pop_front());
      if (xe) push_word(d);
      #1;
   endtask

   function automatic logic [63:0] rx_vec(input int n);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < n && i < rx.size(); i++) v = {v[62:0], rx[i]};
      return v;
   endfunction

   initial begin
      logic             xo;
      int               nx;
      int               k;
      logic [NBITS-1:0] wl[2];
      logic [NBITS-1:0] rec;
      logic             a, b, c;
      int               pos;
      int               flip;

      rst     = 1'b0;
      in_val  = 1'b0;
      in_data = '0;

      // Reset state while rst is held low
      #12;
      chk1("rst_rdy", in_rdy, 1'b1);
      chk1("rst_val", tx_val, 1'b0);
      chk1("rst_bit", tx_bit, 1'b0);
      chk1("rst_sof", tx_sof, 1'b0);
      chk1("rst_eof", tx_eof, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Idle with in_val low
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h3C, xo);

      // Single word 0xA5
      rx.delete();
      cycle(1'b1, 8'hA5, xo);
      for (int i = 0; i < FLEN + 2; i++) cycle(1'b0, 8'h00, xo);
      chk32("a5_len", rx.size(), FLEN);
      chk32("a5_beats", int'(rx_vec(FLEN)), int'(24'b111000111000000111000111));

      // Back-to-back 0xFF then 0x00 with in_val held high
      rx.delete();
      wl[0] = 8'hFF;
      wl[1] = 8'h00;
      nx = 0;
      k  = 0;
      while (nx < 2 && k < 100) begin
         cycle(1'b1, wl[nx], xo);
         if (xo) nx++;
         k++;
      end
      for (int i = 0; i < FLEN + 3; i++) begin
         cycle(1'b0, 8'h55, xo);
         if (xo) nx++;
      end
      chk32("b2b_xfers", nx, 2);
      chk32("b2b_len", rx.size(), 2 * FLEN);
      chk32("b2b_hi", int'(rx_vec(2 * FLEN) >> 24), int'(24'hFFFFFF));
      chk32("b2b_lo", int'(rx_vec(2 * FLEN) & 64'hFFFFFF), 0);

      // Mid-frame in_data change is ignored
      rx.delete();
      cycle(1'b1, 8'h80, xo);
      for (int i = 0; i < FLEN + 2; i++) cycle(1'b0, 8'hFF, xo);
      chk32("mid_beats", int'(rx_vec(FLEN)), int'(24'hE00000));

      // Asynchronous reset during beat 10 of 0xA5
      cycle(1'b1, 8'hA5, xo);
      for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, xo);
      #2;
      rst = 1'b0;
      #1;
      chk1("arst_val", tx_val, 1'b0);
      chk1("arst_rdy", in_rdy, 1'b1);
      chk1("arst_sof", tx_sof, 1'b0);
      chk1("arst_eof", tx_eof, 1'b0);
      chk1("arst_bit", tx_bit, 1'b0);
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 6; i++) cycle(1'b0, 8'hA5, xo);

      // Loopback through a majority voter with one flipped copy per triple
      rx.delete();
      sent.delete();
      k = 0;
      while (sent.size() < 200 && k < 20000) begin
         cycle(($urandom_range(0, 3) != 0), NBITS'($urandom), xo);
         k++;
      end
      k = 0;
      while (q.size() != 0 && k < 100) begin
         cycle(1'b0, 8'h00, xo);
         k++;
      end
      chk32("loop_sent", sent.size(), 200);
      chk32("loop_drain", q.size(), 0);
      chk32("loop_beats", rx.size(), sent.size() * FLEN);
      if (rx.size() == sent.size() * FLEN) begin
         pos = 0;
         for (int w = 0; w < sent.size(); w++) begin
            rec = '0;
            for (int i = 0; i < NBITS; i++) begin
               flip = $urandom_range(0, 2);
               a = rx[pos]     ^ (flip == 0);
               b = rx[pos + 1] ^ (flip == 1);
               c = rx[pos + 2] ^ (flip == 2);
               rec = {rec[NBITS-2:0], (a & b) | (a & c) | (b & c)};
               pos += REPS;
            end
            chk32("loop_word", int'(rec), int'(sent[w]));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
